gost_cfb_ctrl: RTL

- Streaming gamma-with-feedback (CFB) mode controller. Sits directly upstream of the gost_28147_89 core and also consumes its output.
- Accepts 64-bit plaintext or ciphertext words over a valid/ready stream and drives the core's load/pdata/mode.
- Waits for the core's done, XORs the keystream (gamma) with the data word, and emits the result over a valid/ready stream.
- Key loading is outside this block; the core key is held static for the whole message.

---
 rtl/gost_cfb_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gost_cfb_ctrl.sv
// CFB (gamma-with-feedback) controller in front of a GOST 28147-89 core; one word per core op, out_valid core latency + 2 after input.
// Output word is held in OUT until out_ready; input is not accepted again until it drains, so nothing is lost under backpressure.
module gost_cfb_ctrl #(
    parameter int unsigned SWAP         = 1,
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir,
    input  logic [63:0] iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic        core_load,
    output logic        core_mode,
    output logic [63:0] core_pdata,
    input  logic        core_done,
    input  logic [63:0] core_cdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_CORE_GO,
        S_CORE_WAIT,
        S_OUT
    } state_t;

    localparam logic [7:0] TMO = 8'(DONE_TIMEOUT);

    // Full 64-bit byte reversal: byte-swap each half and exchange the halves.
    function automatic logic [63:0] sw(input logic [63:0] x);
        logic [63:0] y;
        y = x;
        if (SWAP != 0) begin
            for (int i = 0; i < 8; i++) begin
                y[i*8 +: 8] = x[(7-i)*8 +: 8];
            end
        end
        return y;
    endfunction

    state_t      state, state_nxt;
    logic [63:0] fb;
    logic [63:0] dbuf;
    logic        dir_q;
    logic        last_q;
    logic [7:0]  timer;
    logic [7:0]  timer_nxt;
    logic [63:0] r;
    logic        timeout;

    assign r          = dbuf ^ core_cdata;
    assign timer_nxt  = timer + 8'd1;
    assign timeout    = (state == S_CORE_WAIT) && !core_done && (timer_nxt == TMO);
    assign core_mode  = 1'b0;
    assign core_pdata = fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_load = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CORE_GO;
            end
            S_CORE_GO: begin
                core_load = 1'b1;
                state_nxt = S_CORE_WAIT;
            end
            S_CORE_WAIT: begin
                if (core_done) begin
                    state_nxt = S_OUT;
                end else if (timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = out_last ? S_IDLE : S_WAIT_IN;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb       <= '0;
            dbuf     <= '0;
            dir_q    <= 1'b0;
            last_q   <= 1'b0;
            timer    <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fb    <= sw(iv);
                        dir_q <= dir;
                        err   <= 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        dbuf   <= sw(in_data);
                        last_q <= in_last;
                    end
                end
                S_CORE_GO: begin
                    timer <= '0;
                end
                S_CORE_WAIT: begin
                    if (core_done) begin
                        out_data <= sw(r);
                        out_last <= last_q;
                        // Feedback is always the ciphertext word, whichever direction.
                        fb       <= dir_q ? dbuf : r;
                    end else begin
                        timer <= timer_nxt;
                        if (timeout) err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
